// File: rtl/phy_rx_pkg.sv
// ============================================================================
// Module   : phy_rx_pkg
// Purpose  : Shared types and constants for the PHY receive aligner.
//            Defines the per-lane alignment state encoding, the default
//            comma byte and the byte width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package phy_rx_pkg;

  // Per-lane alignment state
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } phy_rx_state_e;

  localparam logic [7:0] PHY_RX_COMMA_DEF = 8'hBC;
  localparam int         PHY_RX_BYTE_W    = 8;

endpackage : phy_rx_pkg

`default_nettype wire

// File: rtl/phy_rx_lane.sv
// ============================================================================
// Module   : phy_rx_lane
// Purpose  : Single-lane serial receive aligner. Shifts in one bit per cycle,
//            hunts for the comma at any bit offset, locks after LOCK_COUNT
//            byte-aligned commas and then delivers aligned bytes with a
//            one-cycle strobe and a comma flag.
// Ports    : clk_i    - serial bit clock, all logic on posedge
//            rst_i    - synchronous active-high reset
//            data_i   - serial input bit
//            data_o   - last delivered aligned byte
//            valid_o  - one-cycle strobe per delivered byte
//            comma_o  - delivered byte equals COMMA (qualified by valid_o)
//            active_o - lane locked
// Options  : PHY_RX_TIMEOUT_EN - drop lock after TIMEOUT_BYTES consecutive
//            comma-free locked bytes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_lane
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA         = PHY_RX_COMMA_DEF,
  parameter int         LOCK_COUNT    = 4,
  parameter int         TIMEOUT_BYTES = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     data_i,
  output logic [PHY_RX_BYTE_W-1:0] data_o,
  output logic                     valid_o,
  output logic                     comma_o,
  output logic                     active_o
);

  localparam int CNT_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  // Elaboration-time sanity check of the configuration
  if (LOCK_COUNT < 1 || TIMEOUT_BYTES < 1) begin : g_param_check
    $error("phy_rx_lane: LOCK_COUNT and TIMEOUT_BYTES must be >= 1");
  end

  // Only the seven most recent bits are kept; the eighth comes straight
  // from data_i to form the current byte window.
  logic [PHY_RX_BYTE_W-2:0] sr_q, sr_d;
  phy_rx_state_e            state_q, state_d;
  logic [2:0]               bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PHY_RX_BYTE_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     comma_q, comma_d;
  logic                     active_q, active_d;

  logic [PHY_RX_BYTE_W-1:0] w_win;
  logic                     w_is_comma;
  logic                     w_boundary;

  assign w_win      = {sr_q, data_i};
  assign w_is_comma = (w_win == COMMA);
  assign w_boundary = (bitcnt_q == 3'd7);

`ifdef PHY_RX_TIMEOUT_EN
  localparam int                 TO_W   = $clog2(TIMEOUT_BYTES + 1);
  localparam logic [TO_W-1:0]    TO_MAX = TO_W'(TIMEOUT_BYTES);
  logic [TO_W-1:0] tocnt_q, tocnt_d;
`endif

  always_comb begin
    sr_d     = w_win[PHY_RX_BYTE_W-2:0];
    state_d  = state_q;
    bitcnt_d = bitcnt_q + 3'd1;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    comma_d  = 1'b0;
    active_d = (state_q == LOCKED);
`ifdef PHY_RX_TIMEOUT_EN
    tocnt_d  = (state_q == LOCKED) ? tocnt_q : '0;
`endif

    case (state_q)
      SEARCH: begin
        bitcnt_d = 3'd0;
        if (w_is_comma) begin
          cnt_d   = CNT_W'(1);
          state_d = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
        end
      end

      ALIGN: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            cnt_d = cnt_q + 1'b1;
            if (int'(cnt_q) + 1 == LOCK_COUNT) state_d = LOCKED;
          end else begin
            // Resume hunting from the very next bit
            cnt_d    = '0;
            bitcnt_d = 3'd0;
            state_d  = SEARCH;
          end
        end
      end

      LOCKED: begin
        if (w_boundary) begin
          data_d  = w_win;
          valid_d = 1'b1;
          comma_d = w_is_comma;
`ifdef PHY_RX_TIMEOUT_EN
          if (w_is_comma) begin
            tocnt_d = '0;
          end else begin
            if (tocnt_q != TO_MAX) tocnt_d = tocnt_q + 1'b1;
            // This byte is still delivered; lock is dropped on the same edge
            if (int'(tocnt_q) + 1 >= TIMEOUT_BYTES) begin
              state_d  = SEARCH;
              cnt_d    = '0;
              bitcnt_d = 3'd0;
            end
          end
`endif
        end
      end

      default: begin
        state_d  = SEARCH;
        bitcnt_d = 3'd0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q     <= '0;
      state_q  <= SEARCH;
      bitcnt_q <= 3'd0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      comma_q  <= 1'b0;
      active_q <= 1'b0;
`ifdef PHY_RX_TIMEOUT_EN
      tocnt_q  <= '0;
`endif
    end else begin
      sr_q     <= sr_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      comma_q  <= comma_d;
      active_q <= active_d;
`ifdef PHY_RX_TIMEOUT_EN
      tocnt_q  <= tocnt_d;
`endif
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign comma_o  = comma_q;
  assign active_o = active_q;

endmodule : phy_rx_lane

`default_nettype wire

// File: rtl/phy_rx_align.sv
// ============================================================================
// Module   : phy_rx_align
// Purpose  : Multi-lane PHY receive aligner. Instantiates one independent
//            phy_rx_lane per serial lane and packs the per-lane outputs.
// Ports    : clk_32f   - serial bit clock, all logic on posedge
//            reset     - synchronous active-high reset
//            data_in   - one serial bit per lane
//            data_out  - aligned bytes, lane i in [8i+7:8i]
//            valid_out - per-lane byte strobe
//            comma_out - per-lane comma flag (qualified by valid_out)
//            active    - per-lane lock indication
// Options  : PHY_RX_TIMEOUT_EN - enables loss-of-sync timeout in each lane
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_align
  import phy_rx_pkg::*;
#(
  parameter int         LANES         = 2,
  parameter logic [7:0] COMMA         = PHY_RX_COMMA_DEF,
  parameter int         LOCK_COUNT    = 4,
  parameter int         TIMEOUT_BYTES = 64
) (
  input  logic                           clk_32f,
  input  logic                           reset,
  input  logic [LANES-1:0]               data_in,
  output logic [PHY_RX_BYTE_W*LANES-1:0] data_out,
  output logic [LANES-1:0]               valid_out,
  output logic [LANES-1:0]               comma_out,
  output logic [LANES-1:0]               active
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    phy_rx_lane #(
      .COMMA         (COMMA),
      .LOCK_COUNT    (LOCK_COUNT),
      .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) u_lane (
      .clk_i    (clk_32f),
      .rst_i    (reset),
      .data_i   (data_in[gi]),
      .data_o   (data_out[gi*PHY_RX_BYTE_W +: PHY_RX_BYTE_W]),
      .valid_o  (valid_out[gi]),
      .comma_o  (comma_out[gi]),
      .active_o (active[gi])
    );
  end

endmodule : phy_rx_align

`default_nettype wire
